// File: rtl/debounce_pkg.sv
// Shared types and default timing for the multi-channel key debouncer.
package debounce_pkg;

  // Per-channel debounce FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    P_WAIT  = 2'd1,
    PRESSED = 2'd2,
    R_WAIT  = 2'd3
  } deb_state_t;

  // Default timing at a 1 kHz sample clock
  localparam int DEF_N             = 4;
  localparam int DEF_DEB_CYCLES    = 20;    // 20 ms of stable level to accept an edge
  localparam int DEF_LONG_CYCLES   = 1000;  // 1 s hold before the long-press pulse
  localparam int DEF_REPEAT_CYCLES = 200;   // auto-repeat period after a long press

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, stability counter, hold counter and
// 4-state FSM for an active-low key. Optional auto-repeat is built only when
// DEBOUNCE_REPEAT_EN is defined; otherwise repeat_pulse is constant 0.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  // Catch timing parameters that would make the counters meaningless
  if (DEB_CYCLES < 2 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("debounce_chan: DEB_CYCLES>=2, LONG_CYCLES>=1, REPEAT_CYCLES>=1 required");
  end

  logic [1:0]    sync_reg;
  logic          ks;
  deb_state_t    state_reg, state_next;
  logic [DW-1:0] dcnt_reg, dcnt_next;
  logic [HW-1:0] hcnt_reg, hcnt_next;
  logic          level_reg, level_next;
  logic          press_reg, press_next;
  logic          release_reg, release_next;
  logic          long_reg, long_next;

  assign ks = sync_reg[1];

  // Synchroniser: idles high so a released key looks released straight out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= 2'b11;
    else        sync_reg <= {sync_reg[0], key};
  end

  // FSM, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      dcnt_reg    <= '0;
      hcnt_reg    <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      long_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dcnt_reg    <= dcnt_next;
      hcnt_reg    <= hcnt_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      long_reg    <= long_next;
    end
  end

  // Next-state logic: an edge is accepted after DEB_CYCLES consecutive equal samples
  always_comb begin
    state_next   = state_reg;
    dcnt_next    = dcnt_reg;
    hcnt_next    = hcnt_reg;
    level_next   = level_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    long_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!ks) begin
          state_next = P_WAIT;
          dcnt_next  = DW'(1);
        end
      end
      P_WAIT: begin
        if (ks) begin
          state_next = IDLE;
          dcnt_next  = '0;
        end else if (dcnt_reg == DEB_LAST) begin
          state_next = PRESSED;
          dcnt_next  = '0;
          hcnt_next  = '0;
          level_next = 1'b1;
          press_next = 1'b1;
        end else begin
          dcnt_next = dcnt_reg + 1'b1;
        end
      end
      PRESSED: begin
        if (ks) begin
          state_next = R_WAIT;
          dcnt_next  = DW'(1);
        end else if (hcnt_reg != HOLD_MAX) begin
          // Saturating hold counter; the long pulse fires only on the step that reaches max
          hcnt_next = hcnt_reg + 1'b1;
          long_next = (hcnt_next == HOLD_MAX);
        end
      end
      R_WAIT: begin
        if (!ks) begin
          // Bounce during release: resume the same press, hold time preserved
          state_next = PRESSED;
          dcnt_next  = '0;
        end else if (dcnt_reg == DEB_LAST) begin
          state_next   = IDLE;
          dcnt_next    = '0;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          dcnt_next = dcnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign key_state     = level_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign long_pulse    = long_reg;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rcnt_reg, rcnt_next;
  logic          repeat_reg, repeat_next;

  // Auto-repeat timer: runs only while held in PRESSED after the long press has fired
  always_comb begin
    rcnt_next   = rcnt_reg;
    repeat_next = 1'b0;
    if (state_reg == P_WAIT && state_next == PRESSED) begin
      rcnt_next = '0;
    end else if (state_reg == PRESSED && !ks && hcnt_reg == HOLD_MAX) begin
      if (rcnt_reg == REP_LAST) begin
        rcnt_next   = '0;
        repeat_next = 1'b1;
      end else begin
        rcnt_next = rcnt_reg + 1'b1;
      end
    end
  end

  // Auto-repeat registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_reg   <= '0;
      repeat_reg <= 1'b0;
    end else begin
      rcnt_reg   <= rcnt_next;
      repeat_reg <= repeat_next;
    end
  end

  assign repeat_pulse = repeat_reg;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel debouncer for active-low push keys. Each channel is an independent
// debounce_chan; this level only fans keys out and concatenates the results.
// Optional auto-repeat is enabled by defining DEBOUNCE_REPEAT_EN.
module key_debounce_multi
  import debounce_pkg::*;
#(
  parameter int N             = DEF_N,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] key,
  output logic [N-1:0] key_state,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] long_pulse,
  output logic [N-1:0] repeat_pulse
);

  // One independent debouncer per key pin
  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    debounce_chan #(
      .DEB_CYCLES    (DEB_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .key           (key[gi]),
      .key_state     (key_state[gi]),
      .press_pulse   (press_pulse[gi]),
      .release_pulse (release_pulse[gi]),
      .long_pulse    (long_pulse[gi]),
      .repeat_pulse  (repeat_pulse[gi])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: a run-length reference model predicts
// every output each cycle; a monitor pops and compares on the falling edge.
module tb_key_debounce_multi;

  localparam int N    = 4;
  localparam int DEB  = 20;
  localparam int LONG = 100;
  localparam int REP  = 25;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] key = '1;
  logic [N-1:0] key_state, press_pulse, release_pulse, long_pulse, repeat_pulse;

  key_debounce_multi #(
    .N(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key           (key),
    .key_state     (key_state),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] st;
    logic [N-1:0] pr;
    logic [N-1:0] rl;
    logic [N-1:0] lg;
    logic [N-1:0] rp;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Reference model: accepted level flips after DEB consecutive opposite samples of
  // the key as seen two clocks late; hold time counts pressed samples since acceptance.
  logic [N-1:0] m_s1 = '1, m_s2 = '1;
  bit           m_acc[N];
  int           m_run[N], m_hold[N], m_rep[N];

  initial begin : model
    exp_t e;
    forever begin
      @(posedge clk);
      e = '0;
      if (!rst_n) begin
        m_s1 = '1;
        m_s2 = '1;
        for (int c = 0; c < N; c++) begin
          m_acc[c] = 0; m_run[c] = 0; m_hold[c] = 0; m_rep[c] = 0;
        end
      end else begin
        for (int c = 0; c < N; c++) begin
          logic ks;
          ks = m_s2[c];
          if (!m_acc[c]) begin
            m_run[c] = ks ? 0 : m_run[c] + 1;
            if (m_run[c] == DEB) begin
              m_acc[c] = 1; m_run[c] = 0; m_hold[c] = 0; m_rep[c] = 0;
              e.pr[c] = 1'b1;
            end
          end else if (ks) begin
            m_run[c]++;
            if (m_run[c] == DEB) begin
              m_acc[c] = 0; m_run[c] = 0;
              e.rl[c] = 1'b1;
            end
          end else if (m_run[c] > 0) begin
            m_run[c] = 0;
          end else if (m_hold[c] < LONG) begin
            m_hold[c]++;
            if (m_hold[c] == LONG) e.lg[c] = 1'b1;
          end else begin
`ifdef DEBOUNCE_REPEAT_EN
            m_rep[c]++;
            if (m_rep[c] == REP) begin
              m_rep[c] = 0;
              e.rp[c] = 1'b1;
            end
`endif
          end
          e.st[c] = m_acc[c];
        end
        m_s2 = m_s1;
        m_s1 = key;
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: one expected entry per clock, compared on the falling edge
  initial begin : monitor
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk);
      cyc++;
      vectors++;
      got = {key_state, press_pulse, release_pulse, long_pulse, repeat_pulse};
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL cyc=%0d scoreboard_empty got=%h required=entry", cyc, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL cyc=%0d outputs got st=%b pr=%b rl=%b lg=%b rp=%b required st=%b pr=%b rl=%b lg=%b rp=%b",
                   cyc, got.st, got.pr, got.rl, got.lg, got.rp, e.st, e.pr, e.rl, e.lg, e.rp);
        end
      end
    end
  end

  // Apply a key pattern for n clocks (inputs change 1 time unit after the falling edge)
  task automatic hold(input logic [N-1:0] k, input int n);
    key = k;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin : stimulus
    logic [N-1:0] k;
    int           left[N];

    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;

    $display("[tb] txn 1: key0 low 200, release");
    hold(4'b1110, 200);
    hold(4'b1111, 40);

    $display("[tb] txn 2: key1 bursts 10 low / 5 high x8");
    for (int i = 0; i < 8; i++) begin
      hold(4'b1101, 10);
      hold(4'b1111, 5);
    end
    hold(4'b1111, 30);

    $display("[tb] txn 3: key2 low 300, release");
    hold(4'b1011, 300);
    hold(4'b1111, 40);

    $display("[tb] txn 4: key3 press with 5-clock glitch at hold cycle 60");
    hold(4'b0111, 60);
    hold(4'b1111, 5);
    hold(4'b0111, 100);
    hold(4'b1111, 40);

    $display("[tb] txn 5: key0 and key3 pressed together");
    hold(4'b0110, 50);
    hold(4'b1111, 40);

    $display("[tb] txn 6: reset while key1 held pressed");
    hold(4'b1101, 40);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({key_state, press_pulse, release_pulse, long_pulse, repeat_pulse} !== '0) begin
      miscompares++;
      $display("FAIL cyc=%0d async_reset got st=%b required all zero", cyc, key_state);
    end
    repeat (3) begin
      @(negedge clk);
      #1;
    end
    rst_n = 1'b1;
    hold(4'b1101, 40);
    hold(4'b1111, 40);

    $display("[tb] txn 7: randomized bouncing on all keys");
    k = '1;
    for (int c = 0; c < N; c++) left[c] = 0;
    repeat (1500) begin
      for (int c = 0; c < N; c++) begin
        if (left[c] == 0) begin
          k[c] = ~k[c];
          left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8))
                                                : int'($urandom_range(15, 140));
        end
        left[c]--;
      end
      hold(k, 1);
    end
    hold(4'b1111, 60);

    repeat (2) @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
